fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The module SHALL have the parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have the parameter MEM_TIMEOUT, default 15, giving the maximum number of FETCH cycles without imem_done before an error.
REQ-003 The port clk SHALL be an input, 1 bit wide, serving as the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide; reset is asynchronous and active-high.
REQ-005 The port imem_req SHALL be an output, 1 bit wide, carrying the instruction-memory read request.
REQ-006 The port imem_addr SHALL be an output, 16 bits wide, carrying the fetch address, equal to the current PC.
REQ-007 The port imem_done SHALL be an input, 1 bit wide, pulsed by memory when imem_data is valid.
REQ-008 The port imem_data SHALL be an input, 16 bits wide, carrying the returned instruction word.
REQ-009 The port inst SHALL be an output, 16 bits wide, carrying the held instruction to the decode stage.
REQ-010 The port inst_valid SHALL be an output, 1 bit wide, indicating that inst holds a fetched instruction.
REQ-011 The port pc_plus2 SHALL be an output, 16 bits wide, equal to the PC of the held instruction plus 2.
REQ-012 The port stall SHALL be an input, 1 bit wide, indicating that decode cannot consume the held instruction this cycle.
REQ-013 The port halt SHALL be an input, 1 bit wide, carrying the decoder dump/halt indication for the held instruction.
REQ-014 The port redirect SHALL be an input, 1 bit wide; it is a one-cycle pulse requesting a branch or jump target.
REQ-015 The port redirect_pc SHALL be an input, 16 bits wide, carrying the target address, valid when redirect=1.
REQ-016 The port halted SHALL be an output, 1 bit wide; it is a sticky flag set once the HALTED state is entered.
REQ-017 The port err SHALL be an output, 1 bit wide; it is a sticky flag set on a misaligned target or a memory timeout.
REQ-018 The port fetch_cnt SHALL be an output, 16 bits wide, counting instructions consumed by decode.

Function
REQ-019 The FSM SHALL have exactly four states (IDLE, FETCH, HOLD, HALTED), encoded in 2 bits.
REQ-020 IDLE SHALL transition to FETCH unconditionally on the first clock edge after rst deasserts.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC, both held stable until the cycle imem_done=1.
REQ-022 On FETCH with imem_done=1 and no pending redirect, inst SHALL capture imem_data, and the next state SHALL be HOLD with inst_valid=1 from the following cycle.
REQ-023 A redirect pulse in any non-HALTED state SHALL be latched into a pending-redirect register (flag plus 16-bit target); a later pulse before application SHALL overwrite the earlier one.
REQ-024 On FETCH with imem_done=1 and a pending redirect (including one arriving in the same cycle), the response SHALL be discarded, the PC SHALL load the pending target, pending SHALL clear, and the state SHALL remain FETCH with a new request starting the next cycle.
REQ-025 In HOLD with stall=1, inst, inst_valid and the PC SHALL hold unchanged, and halt SHALL be ignored.
REQ-026 In HOLD with stall=0, fetch_cnt SHALL increment by 1, wrapping from 16'hFFFF to 0.
REQ-027 On that same consume cycle the next PC SHALL be selected by priority: halt=1 goes to HALTED with the PC unchanged; else a pending or same-cycle redirect loads the target and clears pending; else PC+2.
REQ-028 On a consume cycle that does not halt, the state SHALL go to FETCH and inst_valid SHALL drop.
REQ-029 PC arithmetic SHALL be 16-bit unsigned with wrap-around (16'hFFFE+2 = 16'h0000), and pc_plus2 SHALL obey the same rule.
REQ-030 A redirect_pc with bit 0 set SHALL set err and move the FSM to HALTED when that target would be applied.
REQ-031 A timeout counter SHALL clear on FETCH entry; if imem_done is still absent after MEM_TIMEOUT FETCH cycles, err SHALL be set and the FSM SHALL move to HALTED.
REQ-032 HALTED SHALL be absorbing: imem_req=0, inst_valid=0, halted=1, and redirect, imem_done and stall ignored; only rst exits it.
REQ-033 An imem_done arriving outside FETCH SHALL be ignored.

Reset
REQ-034 Asserting rst at any time, including with a fetch outstanding, SHALL immediately force state=IDLE and PC=RESET_PC, and clear inst, inst_valid, imem_req, imem_addr, pending redirect, timeout count, fetch_cnt, halted and err.
REQ-035 While rst is asserted, pc_plus2 SHALL equal RESET_PC+2.
REQ-036 A memory response in flight at reset SHALL be dropped, with no capture after reset release.

Verification
REQ-037 Sequential fetch: reset release, then imem_done one cycle after each request, with stall=0 -> imem_addr sequence 0000,0002,0004 and fetch_cnt=3 after three consumes.
REQ-038 Stall hold: HOLD with inst=16'h4123, stall=1 for 4 cycles -> inst, PC and fetch_cnt unchanged and imem_req=0; fetch resumes at PC+2 on release.
REQ-039 Redirect during fetch: redirect to 16'h0040 while imem_done is 2 cycles away -> response discarded and next imem_addr=16'h0040.
REQ-040 Halt and error: halt=1 with stall=0 -> halted=1 and imem_req=0 thereafter; redirect_pc=16'h0031 applied -> err=1 and HALTED; a MEM_TIMEOUT-cycle silent memory -> err=1.
REQ-041 Wrap and reset: PC=16'hFFFE consumed -> next imem_addr=16'h0000; rst asserted mid-FETCH -> all outputs cleared asynchronously and a late imem_done ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues PC-addressed memory reads, holds the returned
// word for decode, and tracks redirects, halt, memory timeout and a consume counter.
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_done,
   input  logic [15:0] imem_data,
   output logic [15:0] inst,
   output logic        inst_valid,
   output logic [15:0] pc_plus2,
   input  logic        stall,
   input  logic        halt,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        halted,
   output logic        err,
   output logic [15:0] fetch_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, HALTED = 2'd3} state_t;

   localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state_reg, state_next;
   logic [15:0] pc_reg, pc_next;
   logic [15:0] inst_reg, inst_next;
   logic        pend_reg, pend_next;
   logic [15:0] pend_pc_reg, pend_pc_next;
   logic [15:0] tmo_reg, tmo_next;
   logic        err_reg, err_next;
   logic [15:0] cnt_reg, cnt_next;

   // A redirect arriving this cycle takes precedence over an older latched one.
   logic        eff_pend;
   logic [15:0] eff_pc;
   assign eff_pend = pend_reg | redirect;
   assign eff_pc   = redirect ? redirect_pc : pend_pc_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         pc_reg      <= RESET_PC;
         inst_reg    <= 16'h0000;
         pend_reg    <= 1'b0;
         pend_pc_reg <= 16'h0000;
         tmo_reg     <= 16'h0000;
         err_reg     <= 1'b0;
         cnt_reg     <= 16'h0000;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         inst_reg    <= inst_next;
         pend_reg    <= pend_next;
         pend_pc_reg <= pend_pc_next;
         tmo_reg     <= tmo_next;
         err_reg     <= err_next;
         cnt_reg     <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      inst_next    = inst_reg;
      pend_next    = pend_reg;
      pend_pc_next = pend_pc_reg;
      tmo_next     = tmo_reg;
      err_next     = err_reg;
      cnt_next     = cnt_reg;
      if (redirect && state_reg != HALTED) begin
         pend_next    = 1'b1;
         pend_pc_next = redirect_pc;
      end
      case (state_reg)
         IDLE: begin
            state_next = FETCH;
            tmo_next   = 16'h0000;
         end
         FETCH: begin
            if (imem_done) begin
               tmo_next = 16'h0000;
               if (eff_pend) begin
                  // Response belongs to the abandoned path; refetch at the target.
                  pend_next = 1'b0;
                  if (eff_pc[0]) begin
                     err_next   = 1'b1;
                     state_next = HALTED;
                  end else begin
                     pc_next = eff_pc;
                  end
               end else begin
                  inst_next  = imem_data;
                  state_next = HOLD;
               end
            end else if (tmo_reg == TMO_LAST) begin
               err_next   = 1'b1;
               state_next = HALTED;
            end else begin
               tmo_next = tmo_reg + 16'd1;
            end
         end
         HOLD: begin
            if (!stall) begin
               cnt_next = cnt_reg + 16'd1;
               if (halt) begin
                  state_next = HALTED;
               end else begin
                  state_next = FETCH;
                  tmo_next   = 16'h0000;
                  if (eff_pend) begin
                     pend_next = 1'b0;
                     if (eff_pc[0]) begin
                        err_next   = 1'b1;
                        state_next = HALTED;
                     end else begin
                        pc_next = eff_pc;
                     end
                  end else begin
                     pc_next = pc_reg + 16'd2;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      imem_req   = (state_reg == FETCH);
      inst_valid = (state_reg == HOLD);
      halted     = (state_reg == HALTED);
      imem_addr  = pc_reg;
      pc_plus2   = pc_reg + 16'd2;
      inst       = inst_reg;
      err        = err_reg;
      fetch_cnt  = cnt_reg;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_done = 1'b0;
   logic [15:0] imem_data = 16'h0000;
   logic [15:0] inst;
   logic        inst_valid;
   logic [15:0] pc_plus2;
   logic        stall = 1'b0;
   logic        halt = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halted;
   logic        err;
   logic [15:0] fetch_cnt;

   int errors = 0;
   int checks = 0;

   fetch_ctrl dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_done(imem_done), .imem_data(imem_data),
      .inst(inst), .inst_valid(inst_valid), .pc_plus2(pc_plus2),
      .stall(stall), .halt(halt),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .halted(halted), .err(err), .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   // Advance one clock edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_done = 1'b0; stall = 1'b0; halt = 1'b0; redirect = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
      checks++; if (inst_valid !== 1'b0 || inst !== 16'h0000) begin errors++; $display("FAIL reset_inst got=%b/%h exp=0/0000", inst_valid, inst); end
      checks++; if (pc_plus2 !== 16'h0002) begin errors++; $display("FAIL reset_pcp2 got=%h exp=0002", pc_plus2); end
      checks++; if (halted !== 1'b0 || err !== 1'b0 || fetch_cnt !== 16'h0000) begin errors++; $display("FAIL reset_flags got=%b/%b/%h exp=0/0/0000", halted, err, fetch_cnt); end
      rst = 1'b0;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL first_fetch got=%b/%h exp=1/0000", imem_req, imem_addr); end
      $display("reset: req=%b addr=%h", imem_req, imem_addr);
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 16'(2 * i)) begin errors++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 16'(2 * i)); end
         imem_done = 1'b1; imem_data = 16'(16'h1000 + i);
         step();
         imem_done = 1'b0;
         checks++; if (inst_valid !== 1'b1 || inst !== 16'(16'h1000 + i) || pc_plus2 !== 16'(2 * i + 2)) begin errors++; $display("FAIL seq_hold%0d got=%b/%h/%h", i, inst_valid, inst, pc_plus2); end
         step();
         checks++; if (fetch_cnt !== 16'(i + 1) || inst_valid !== 1'b0) begin errors++; $display("FAIL seq_cnt%0d got=%h/%b exp=%h/0", i, fetch_cnt, inst_valid, 16'(i + 1)); end
         $display("seq %0d: addr=%h cnt=%h", i, imem_addr, fetch_cnt);
      end
      checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL seq_next got=%h exp=0006", imem_addr); end
   endtask

   task automatic test_stall();
      imem_done = 1'b1; imem_data = 16'h4123;
      step();
      imem_data = 16'h9999; stall = 1'b1; halt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (inst_valid !== 1'b1 || inst !== 16'h4123 || pc_plus2 !== 16'h0008 || fetch_cnt !== 16'h0003 || imem_req !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL stall%0d got=%b/%h/%h/%h/%b/%b", i, inst_valid, inst, pc_plus2, fetch_cnt, imem_req, halted);
         end
      end
      imem_done = 1'b0; stall = 1'b0; halt = 1'b0;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008 || fetch_cnt !== 16'h0004) begin errors++; $display("FAIL stall_release got=%b/%h/%h exp=1/0008/0004", imem_req, imem_addr, fetch_cnt); end
      $display("stall: resumed addr=%h cnt=%h", imem_addr, fetch_cnt);
   endtask

   task automatic test_redirect();
      redirect = 1'b1; redirect_pc = 16'h0040;
      step();
      redirect = 1'b0;
      step();
      checks++; if (imem_addr !== 16'h0008 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_stable got=%b/%h exp=1/0008", imem_req, imem_addr); end
      imem_done = 1'b1; imem_data = 16'hDEAD;
      step();
      imem_done = 1'b0;
      checks++; if (imem_addr !== 16'h0040 || inst_valid !== 1'b0 || inst !== 16'h4123 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_discard got=%h/%b/%h exp=0040/0/4123", imem_addr, inst_valid, inst); end
      imem_done = 1'b1; imem_data = 16'h1111;
      step();
      imem_done = 1'b0;
      checks++; if (inst !== 16'h1111 || pc_plus2 !== 16'h0042) begin errors++; $display("FAIL redir_fetch got=%h/%h exp=1111/0042", inst, pc_plus2); end
      // Same-cycle redirect on a consume cycle, landing on the wrap boundary.
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      step();
      redirect = 1'b0;
      checks++; if (imem_addr !== 16'hFFFE || fetch_cnt !== 16'h0005) begin errors++; $display("FAIL redir_consume got=%h/%h exp=FFFE/0005", imem_addr, fetch_cnt); end
      $display("redirect: addr=%h cnt=%h", imem_addr, fetch_cnt);
   endtask

   task automatic test_wrap();
      imem_done = 1'b1; imem_data = 16'h2222;
      step();
      imem_done = 1'b0;
      checks++; if (pc_plus2 !== 16'h0000 || inst !== 16'h2222) begin errors++; $display("FAIL wrap_pcp2 got=%h/%h exp=0000/2222", pc_plus2, inst); end
      step();
      checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1 || fetch_cnt !== 16'h0006) begin errors++; $display("FAIL wrap_addr got=%h/%b/%h exp=0000/1/0006", imem_addr, imem_req, fetch_cnt); end
      $display("wrap: addr=%h", imem_addr);
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 14; i++) step();
      checks++; if (imem_req !== 1'b1 || err !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b/%b/%b exp=1/0/0", imem_req, err, halted); end
      step();
      checks++; if (err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL tmo_err got=%b/%b/%b exp=1/1/0", err, halted, imem_req); end
      redirect = 1'b1; redirect_pc = 16'h0100; imem_done = 1'b1; stall = 1'b1;
      step(); step();
      redirect = 1'b0; imem_done = 1'b0; stall = 1'b0;
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halted_absorb got=%b/%b/%b/%h", halted, imem_req, inst_valid, imem_addr); end
      $display("timeout: err=%b halted=%b", err, halted);
   endtask

   task automatic test_reset_midfetch();
      do_reset();
      imem_done = 1'b1; imem_data = 16'h3333;
      step();
      imem_done = 1'b0;
      step();
      checks++; if (imem_addr !== 16'h0002 || fetch_cnt !== 16'h0001) begin errors++; $display("FAIL mid_setup got=%h/%h exp=0002/0001", imem_addr, fetch_cnt); end
      rst = 1'b1; imem_done = 1'b1; imem_data = 16'hBEEF;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || fetch_cnt !== 16'h0000 || inst !== 16'h0000 || pc_plus2 !== 16'h0002) begin
         errors++; $display("FAIL async_rst got=%b/%h/%h/%h/%h", imem_req, imem_addr, fetch_cnt, inst, pc_plus2);
      end
      step();
      rst = 1'b0;
      step();
      imem_done = 1'b0;
      checks++; if (inst_valid !== 1'b0 || inst !== 16'h0000 || imem_req !== 1'b1) begin errors++; $display("FAIL late_done got=%b/%h/%b exp=0/0000/1", inst_valid, inst, imem_req); end
      step();
      checks++; if (inst_valid !== 1'b0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL late_done2 got=%b/%h exp=0/0000", inst_valid, imem_addr); end
      $display("reset mid-fetch: req=%b inst=%h", imem_req, inst);
   endtask

   task automatic test_halt();
      imem_done = 1'b1; imem_data = 16'h5555;
      step();
      imem_done = 1'b0; halt = 1'b1;
      step();
      halt = 1'b0;
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || err !== 1'b0 || fetch_cnt !== 16'h0001 || imem_addr !== 16'h0000) begin
         errors++; $display("FAIL halt got=%b/%b/%b/%h/%h", halted, imem_req, err, fetch_cnt, imem_addr);
      end
      step(); step();
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_sticky got=%b/%b exp=1/0", halted, imem_req); end
      $display("halt: halted=%b", halted);
   endtask

   task automatic test_misaligned();
      do_reset();
      redirect = 1'b1; redirect_pc = 16'h0031;
      step();
      redirect = 1'b0; imem_done = 1'b1; imem_data = 16'h7777;
      checks++; if (err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL misal_pending got=%b/%b exp=0/1", err, imem_req); end
      step();
      imem_done = 1'b0;
      checks++; if (err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || inst !== 16'h0000) begin errors++; $display("FAIL misal got=%b/%b/%b/%h exp=1/1/0/0000", err, halted, imem_req, inst); end
      $display("misaligned: err=%b halted=%b", err, halted);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_wrap();
      test_timeout();
      test_reset_midfetch();
      test_halt();
      test_misaligned();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
